dmem_master: RTL and testbench

- Initiator-side data-memory port controller placed between the single-cycle/multi-cycle datapath's load/store logic and the word-wide data SRAM.
- Converts one CPU load/store request into SRAM chip-select, output-enable and write-enable strobes.
- Handles byte and halfword accesses, sign/zero extension, and misalignment detection.
- Performs read-modify-write for sub-word stores, because the SRAM has no byte enables.

---
 rtl/dmem_master.sv | 154 +++++++++++++++
 tb/tb_dmem_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_master.sv
// Data-memory port controller: CPU load/store -> SRAM strobes, sub-word RMW, extension, misalign detect.
// Latency from accept: word store 2, load RD_LATENCY+1, sub-word store RD_LATENCY+2, error 2; one request in flight.
module dmem_master #(
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, RD, WR, ERR, RESP} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;

    logic        req_bad;
    logic [4:0]  lane_sh;
    logic [31:0] lane_mask;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_bad = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // Byte/half lanes are located by a shift of the word; big-endian mirrors the offset.
    always_comb begin
        lane_sh   = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        if (lat_size == 2'b00) begin
            lane_mask = 32'h0000_00FF;
            lane_sh   = BIG_ENDIAN ? {~lat_off, 3'b000} : {lat_off, 3'b000};
        end else if (lat_size == 2'b01) begin
            lane_mask = 32'h0000_FFFF;
            lane_sh   = BIG_ENDIAN ? {~lat_off[1], 4'b0000} : {lat_off[1], 4'b0000};
        end
        lane   = (mem_dout >> lane_sh) & lane_mask;
        merged = (mem_dout & ~(lane_mask << lane_sh)) | ((lat_wdata & lane_mask) << lane_sh);
        case (lat_size)
            2'b00:   load_ext = lat_signed ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
            2'b01:   load_ext = lat_signed ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
            default: load_ext = mem_dout;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_off    <= 2'b00;
            lat_wdata  <= 32'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_cs     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_din    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_off    <= req_addr[1:0];
                        lat_wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        if (req_bad) begin
                            state <= ERR;
                        end else if (!req_we || req_size != 2'b10) begin
                            state  <= RD;
                            cnt    <= 3'(RD_LATENCY - 1);
                            mem_cs <= 1'b1;
                            mem_oe <= 1'b1;
                        end else begin
                            state   <= WR;
                            mem_cs  <= 1'b1;
                            mem_we  <= 1'b1;
                            mem_din <= req_wdata;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD: begin
                    if (cnt == 3'd0) begin
                        mem_oe <= 1'b0;
                        if (lat_we) begin
                            state   <= WR;
                            mem_we  <= 1'b1;
                            mem_din <= merged;
                        end else begin
                            state      <= RESP;
                            mem_cs     <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_ext;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_cs     <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                end
                ERR: begin
                    state      <= RESP;
                    resp_err   <= 1'b1;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench: two DUTs (RD_LATENCY 1 and 3) share request inputs; sel picks which one is observed.
module tb_dmem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        sel;

    logic        rdy1, rv1, err1, cs1, oe1, we1;
    logic [31:0] rdata1, addr1, din1, dout1;
    logic        rdy3, rv3, err3, cs3, oe3, we3;
    logic [31:0] rdata3, addr3, din3, dout3;

    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] din;
        logic [31:0] waddr;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dmem_master #(.RD_LATENCY(1), .BIG_ENDIAN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rdata1), .resp_err(err1), .mem_cs(cs1), .mem_oe(oe1),
        .mem_we(we1), .mem_addr(addr1), .mem_din(din1), .mem_dout(dout1));

    dmem_master #(.RD_LATENCY(3), .BIG_ENDIAN(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_rdata(rdata3), .resp_err(err3), .mem_cs(cs3), .mem_oe(oe3),
        .mem_we(we3), .mem_addr(addr3), .mem_din(din3), .mem_dout(dout3));

    // Word-wide SRAM models with no byte enables.
    assign dout1 = mem1[addr1[7:2]];
    assign dout3 = mem3[addr3[7:2]];
    always @(posedge clk) begin
        if (cs1 && we1) mem1[addr1[7:2]] <= din1;
        if (cs3 && we3) mem3[addr3[7:2]] <= din3;
    end

    logic        o_rdy, o_rv, o_err, o_cs, o_oe, o_we;
    logic [31:0] o_rdata, o_addr, o_din;
    assign o_rdy   = sel ? rdy3   : rdy1;
    assign o_rv    = sel ? rv3    : rv1;
    assign o_err   = sel ? err3   : err1;
    assign o_cs    = sel ? cs3    : cs1;
    assign o_oe    = sel ? oe3    : oe1;
    assign o_we    = sel ? we3    : we1;
    assign o_rdata = sel ? rdata3 : rdata1;
    assign o_addr  = sel ? addr3  : addr1;
    assign o_din   = sel ? din3   : din1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [31:0] exp_din);
        int   L;
        int   rd, wr, lat, waits;
        logic bad, inv_bad, addr_bad, rdy_seen;
        logic [31:0] din_seen, rdata_seen;
        logic err_seen;
        exp_t e, g;
        L   = sel ? 3 : 1;
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        e.rdata = (we || bad) ? 32'd0 : exp_rdata;
        e.err   = bad;
        e.din   = exp_din;
        e.waddr = {addr[31:2], 2'b00};
        if (bad)                     begin e.lat = 2;     e.rd = 0; e.wr = 0; end
        else if (!we)                begin e.lat = L + 1; e.rd = L; e.wr = 0; end
        else if (size == 2'b10)      begin e.lat = 2;     e.rd = 0; e.wr = 1; end
        else                         begin e.lat = L + 2; e.rd = L; e.wr = 1; end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        waits = 0;
        while (!o_rdy && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, "_ready"}, {31'd0, o_rdy}, 32'd1);
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        // Drop valid and scramble the request to show it is ignored once accepted.
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_size = ~size; req_we = ~we;

        rd = 0; wr = 0; lat = 0; inv_bad = 0; addr_bad = 0; rdy_seen = 0;
        din_seen = 32'hx; rdata_seen = 32'hx; err_seen = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_oe) rd++;
            if (o_we) begin wr++; din_seen = o_din; end
            if (o_oe && o_we) inv_bad = 1;
            if (o_cs !== (o_oe | o_we)) inv_bad = 1;
            if (o_cs && o_addr !== e.waddr) addr_bad = 1;
            if (o_rdy) rdy_seen = 1;
            if (o_rv) begin
                lat = c; rdata_seen = o_rdata; err_seen = o_err;
                break;
            end
        end
        g = sb_q.pop_front();
        chk({tag, "_lat"}, lat, g.lat);
        chk({tag, "_rdata"}, rdata_seen, g.rdata);
        chk({tag, "_err"}, {31'd0, err_seen}, {31'd0, g.err});
        chk({tag, "_rdcyc"}, rd, g.rd);
        chk({tag, "_wrcyc"}, wr, g.wr);
        if (g.wr != 0) chk({tag, "_din"}, din_seen, g.din);
        chk({tag, "_strobes"}, {30'd0, inv_bad, addr_bad}, 32'd0);
        chk({tag, "_busy_ready"}, {31'd0, rdy_seen}, 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, {30'd0, o_rv, o_rdy}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) begin mem1[i] = 32'h0; mem3[i] = 32'h0; end
        mem1[8]  = 32'h12F4_5678;
        mem1[12] = 32'hAABB_CCDD;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {26'd0, o_rdy, o_rv, o_err, o_cs, o_oe, o_we}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_din", o_din, 32'd0);
        rst_n = 1'b1;

        xfer("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
        xfer("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);
        xfer("lb21",  1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'hFFFF_FFF4, 32'h0);
        xfer("lbu21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000_00F4, 32'h0);
        xfer("lh22",  1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000_5678, 32'h0);
        xfer("lb20",  1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0000_0012, 32'h0);
        xfer("sb33",  1'b1, 2'b00, 1'b0, 32'h33, 32'h0000_0011, 32'h0, 32'hAABB_CC11);
        mem1[12] = 32'hAABB_CCDD;
        xfer("sh30",  1'b1, 2'b01, 1'b0, 32'h30, 32'h0000_1234, 32'h0, 32'h1234_CCDD);
        xfer("lw30",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h1234_CCDD, 32'h0);
        xfer("lh32n", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'hFFFF_CCDD, 32'h0);
        xfer("lw06",  1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 32'h0);
        xfer("sh01",  1'b1, 2'b01, 1'b0, 32'h01, 32'h5555, 32'h0, 32'h0);
        xfer("sz11",  1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 32'h0);

        repeat (10) @(negedge clk);
        sel = 1'b1;
        mem3[16] = 32'hCAFE_F00D;
        xfer("lw40_l3", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 32'h0);
        xfer("lbu43_l3", 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'h0000_000D, 32'h0);
        repeat (10) @(negedge clk);
        sel = 1'b0;

        // Reset during the first RD cycle of a sub-word store.
        mem1[12] = 32'hAABB_CCDD;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h33; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        chk("mid_rd_strobe", {30'd0, o_cs, o_oe}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_drop", {27'd0, o_rdy, o_rv, o_cs, o_oe, o_we}, 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_hold", {27'd0, o_rdy, o_rv, o_cs, o_oe, o_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, o_rdy}, 32'd1);
        chk("post_rst_mem", mem1[12], 32'hAABB_CCDD);
        xfer("lw30_post", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hAABB_CCDD, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
